// File: rtl/angstrom_pkg.sv
// Shared constants for the OUT-port UART transmitter.
// FSM state encoding and default sizing.
package angstrom_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/out_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers.
// Pushes into a full FIFO and pops from an empty one are ignored.
module out_fifo
  import angstrom_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/out_uart_tx.sv
// Buffered 8N1 UART transmitter fed by the CPU OUT port.
// Define OUT_UART_PARITY_EN to add an even-parity bit (8E1).
module out_uart_tx
  import angstrom_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       wr_en_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       tx_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          ovf;
  logic          pop;
  logic          tc;
  logic          f_empty;
  logic          f_full;
  logic [7:0]    f_dout;

  out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (wr_en_i),
    .pop   (pop),
    .din   (data_i),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  assign tc  = (baud == BAUD_MAX);
  assign pop = !f_empty &&
               ((state == IDLE) ||
                (state == STOP && tc));

  assign full_o = f_full;
  assign busy_o = (state != IDLE) || !f_empty;
  assign ovf_o  = ovf;
  assign tx_o   = tx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      if (wr_en_i && f_full)
        ovf <= 1'b1;
      if (state == IDLE || tc)
        baud <= '0;
      else
        baud <= baud + BW'(1);
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg <= f_dout;
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (tc) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
          end
        end
        DATA: begin
          if (tc) begin
            if (bit_cnt == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
              state <= PARITY;
              tx_q  <= ^shreg;
`else
              state <= STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shreg[bit_cnt + 3'd1];
            end
          end
        end
`ifdef OUT_UART_PARITY_EN
        PARITY: begin
          if (tc) begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tc) begin
            // Chain straight into the next frame when data waits
            if (pop) begin
              shreg <= f_dout;
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// Self-checking bench for out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Decodes the serial line and compares against queued expected bytes.
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LIMIT = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data = '0;
  logic       full;
  logic       busy;
  logic       ovf;
  logic       tx;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .wr_en_i (wr_en),
    .data_i  (data),
    .full_o  (full),
    .busy_o  (busy),
    .ovf_o   (ovf),
    .tx_o    (tx)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    data  = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Line level for each bit slot of a frame carrying b
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef OUT_UART_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Mid-bit sampling receiver; gap = ticks until start bit seen
  task automatic rx_frame(output logic [7:0] d, output logic par,
                          output logic stp, output int gap,
                          output bit to);
    d = '0;
    par = 1'b0;
    stp = 1'b0;
    gap = 0;
    to = 1'b0;
    while (1) begin
      tick();
      gap++;
      if (tx === 1'b0) break;
      if (gap >= LIMIT) begin
        to = 1'b1;
        break;
      end
    end
    if (to) return;
    repeat (CPB / 2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      d[i] = tx;
    end
`ifdef OUT_UART_PARITY_EN
    repeat (CPB) tick();
    par = tx;
`endif
    repeat (CPB) tick();
    stp = tx;
  endtask

  task automatic check_frames(input string nm, input logic [7:0] exp[$]);
    logic [7:0] d;
    logic par, stp;
    int gap;
    bit to;
    foreach (exp[i]) begin
      rx_frame(d, par, stp, gap, to);
      total++;
      if (to) begin
        bad++;
        $display("FAIL %s frame %0d: timeout waiting for start bit", nm, i);
        return;
      end
      if (d !== exp[i]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %h want %h", nm, i, d, exp[i]);
      end
      total++;
      if (stp !== 1'b1) begin
        bad++;
        $display("FAIL %s stop[%0d]: got %b want 1", nm, i, stp);
      end
      total++;
      if (gap !== 2) begin
        bad++;
        $display("FAIL %s gap[%0d]: got %0d want 2", nm, i, gap);
      end
`ifdef OUT_UART_PARITY_EN
      total++;
      if (par !== ^exp[i]) begin
        bad++;
        $display("FAIL %s parity[%0d]: got %b want %b", nm, i, par, ^exp[i]);
      end
`endif
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (3) tick();
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [10:0] f;
    f = frame_bits(8'hA5);
    wr(8'hA5);
    for (int j = 0; j < NBITS * CPB; j++) begin
      tick();
      total++;
      if (tx !== f[j / CPB]) begin
        bad++;
        $display("FAIL single_tx cyc %0d: got %b want %b", j, tx, f[j / CPB]);
      end
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hi: got %b want 1", busy); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_lo: got %b want 0", busy); end
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx: got %b want 1", tx); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[$];
    bit seen;
    exp = '{8'h01, 8'h02, 8'h03};
    seen = 1'b0;
    fork
      check_frames("b2b", exp);
      begin
        foreach (exp[i]) begin
          wr(exp[i]);
          seen |= full;
        end
        repeat (40) begin
          tick();
          seen |= full;
        end
      end
    join
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL b2b_full: got 1 want 0"); end
    repeat (CPB) tick();
  endtask

  task automatic test_overflow;
    logic [7:0] exp[$];
    bit quiet;
    exp = '{8'hAA, 8'h10, 8'h11, 8'h12, 8'h13};
    fork
      check_frames("ovf", exp);
      begin
        wr(8'hAA);
        wr(8'h10);
        wr(8'h11);
        wr(8'h12);
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL ovf_full3: got %b want 0", full); end
        wr(8'h13);
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL ovf_full4: got %b want 1", full); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
        wr(8'h14);
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
      end
    join
    quiet = 1'b1;
    repeat (3 * NBITS * CPB) begin
      tick();
      if (tx !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL ovf_dropped: got extra frame want none"); end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    tick();
  endtask

  task automatic test_pushpop;
    logic [7:0] exp[$];
    exp = {};
    for (int i = 0; i < 6; i++) exp.push_back(8'($urandom));
    fork
      check_frames("pushpop", exp);
      begin
        wr(exp[0]);
        wr(exp[1]);
        wr(exp[2]);
        repeat (NBITS * CPB - 2) tick();
        wr(exp[3]);
        wr(exp[4]);
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL pushpop_occ3: got full=%b want 0", full); end
        wr(exp[5]);
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL pushpop_occ4: got full=%b want 1", full); end
      end
    join
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL pushpop_ovf: got %b want 0", ovf); end
    repeat (CPB) tick();
  endtask

  task automatic test_reset_midframe;
    logic [7:0] bytes[2];
    bit quiet;
    bytes = '{8'hFF, 8'h00};
    foreach (bytes[r]) begin
      wr(bytes[r]);
      wr(8'h55);
      repeat (17) tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre[%0d]: got %b want 1", r, busy); end
      rst_n = 1'b0;
      wr_en = 1'b1;
      data = 8'h33;
      tick();
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx[%0d]: got %b want 1", r, tx); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy[%0d]: got %b want 0", r, busy); end
      rst_n = 1'b1;
      wr_en = 1'b0;
      quiet = 1'b1;
      repeat (3 * NBITS * CPB) begin
        tick();
        if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin bad++; $display("FAIL midrst_quiet[%0d]: got activity want idle", r); end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp[$];
    int k;
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 4);
      exp = {};
      for (int i = 0; i < k; i++) exp.push_back(8'($urandom));
      fork
        check_frames("random", exp);
        begin
          foreach (exp[i]) wr(exp[i]);
        end
      join
      repeat (CPB) tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL random_busy[%0d]: got %b want 0", r, busy); end
    end
  endtask

`ifdef OUT_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] d;
    logic par, stp;
    int gap;
    bit to;
    logic [7:0] bytes[2];
    logic exp_par[2];
    bytes = '{8'h07, 8'h03};
    exp_par = '{1'b1, 1'b0};
    fork
      begin
        foreach (bytes[i]) begin
          rx_frame(d, par, stp, gap, to);
          total++;
          if (to || par !== exp_par[i] || gap !== 2) begin
            bad++;
            $display("FAIL parity_bit[%0d]: got par=%b gap=%0d want par=%b gap=2",
                     i, par, gap, exp_par[i]);
          end
        end
      end
      begin
        wr(bytes[0]);
        wr(bytes[1]);
      end
    join
    repeat (CPB) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pushpop();
    test_reset_midframe();
    test_random();
`ifdef OUT_UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_uart_tx.md
OUT_UART_TX -- requirements
Module: out_uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 2..4095.
- REQ-002: Parameter FIFO_DEPTH, default 4; byte buffer depth, a power of two, range 2..16.
- REQ-003: clk_i  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst_n_i  input  1  reset, synchronous and active-low.
- REQ-005: wr_en_i  input  1  write strobe; driven by the CPU OUT-enable.
- REQ-006: data_i  input  8  byte to transmit; the CPU OUT register value, sampled only when wr_en_i=1.
- REQ-007: full_o  output  1  FIFO holds FIFO_DEPTH bytes.
- REQ-008: busy_o  output  1  FSM not IDLE, or FIFO non-empty.
- REQ-009: ovf_o  output  1  sticky overflow flag.
- REQ-010: tx_o  output  1  serial line; idle high.

Function
- REQ-011: A write with wr_en_i=1 and full_o=0 pushes data_i into the FIFO at that edge; occupancy increments.
- REQ-012: A write with full_o=1 drops the byte and sets ovf_o, even if a pop occurs on the same edge.
- REQ-013: ovf_o stays set until reset.
- REQ-014: The FSM has states IDLE, START, DATA, PARITY (macro only), and STOP.
- REQ-015: In IDLE with the FIFO non-empty, the FSM pops the head byte into the shift register at the next edge and enters START.
- REQ-016: Latency: a byte written at edge k into an empty, idle block drives tx_o=0 from edge k+1.
- REQ-017: The START state drives tx_o=0 for CLKS_PER_BIT cycles.
- REQ-018: The DATA state drives 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit counter runs 0..7.
- REQ-019: The STOP state drives tx_o=1 for CLKS_PER_BIT cycles.
- REQ-020: At the end of STOP, the FSM enters START directly if the FIFO is non-empty, popping at that edge, with no idle gap; otherwise it enters IDLE.
- REQ-021: The baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the bit at terminal count; it is held at 0 in IDLE.
- REQ-022: The FIFO read and write pointers are log2(FIFO_DEPTH) bits plus a wrap bit.
- REQ-023: full_o = (pointer MSBs differ) and (low bits equal); empty = (pointers equal).
- REQ-024: A simultaneous push and pop with the FIFO neither empty nor full leaves occupancy unchanged.
- REQ-025: A push into an empty FIFO is not visible to the FSM until the following cycle; there is no bypass.
- REQ-026: tx_o is registered and glitch-free.

Reset
- REQ-027: When rst_n_i=0 at an edge, the block clears the FIFO pointers, FSM=IDLE, counters=0, tx_o=1, full_o=0, busy_o=0, and ovf_o=0.
- REQ-028: Reset mid-frame aborts the frame: tx_o=1 from the reset edge, and buffered bytes are discarded.
- REQ-029: A write asserted during reset is ignored.

Configuration
- REQ-030: Macro OUT_UART_PARITY_EN.
  - Defined: PARITY state after DATA drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame length is 11 bits.
  - Undefined: DATA goes directly to STOP; frame length is 10 bits; no parity logic is present.

Structure
- REQ-031: Shared package angstrom_pkg holds:
  - FSM state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - The default CLKS_PER_BIT and FIFO_DEPTH constants.
- REQ-032: One sub-module, out_fifo: synchronous byte FIFO with push, pop, dout, full, and empty ports. out_uart_tx instantiates it once and holds the FSM and baud logic.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
- REQ-033: Single byte: write 0xA5 once -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting 1 cycle after the write; busy_o falls after 40 cycles; ovf_o=0.
- REQ-034: Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle bits between them; full_o is never asserted.
- REQ-035: Overflow: while a frame is in progress, write 5 bytes 0x10..0x14 -> full_o=1 after the fourth write, 0x14 is dropped and ovf_o=1; the 4 buffered bytes transmit in order 0x10..0x13.
- REQ-036: Reset mid-frame: assert rst_n_i=0 in bit 3 of the 0xFF frame -> tx_o=1 on the next edge, busy_o=0, and no further frames after release.
- REQ-037: Parity (macro defined): write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; each frame is 44 cycles.
- REQ-038: Simultaneous push and pop: FIFO holding 2 bytes, write on the STOP-to-START edge -> occupancy stays 2 and byte order is preserved.
